// File: rtl/tile_buffer_loader.sv
// Serial-loaded tile RAM for the VGA text renderer: 8N1 receiver, packet decoder
// (FF col row code / FF FE clear), and a registered read port for the pixel pipeline.
module tile_buffer_loader #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         COLS         = 40,
  parameter int         ROWS         = 15,
  parameter logic [7:0] CLEAR_CODE   = 8'h00
) (
  input  logic       master_clk,
  input  logic       reset_n,
  input  logic       data,
  input  logic [5:0] rd_col,
  input  logic [3:0] rd_row,
  output logic [7:0] rd_code,
  output logic       busy,
  output logic       pkt_done,
  output logic       err
);
  localparam int             CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]  HALF_BIT  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0]  FULL_BIT  = CW'(CLKS_PER_BIT);
  localparam logic [7:0]     COLS_B    = 8'(COLS);
  localparam logic [7:0]     ROWS_B    = 8'(ROWS);
  localparam logic [9:0]     LAST_ADDR = 10'(ROWS * COLS - 1);

  logic sync1, rxd;

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      rxd   <= 1'b1;
    end else begin
      sync1 <= data;
      rxd   <= sync1;
    end
  end

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    rx_byte, byte_next;
  logic          byte_valid, valid_next;
  logic          frame_err, ferr_next;

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_next;
      cnt        <= cnt_next;
      bit_idx    <= bit_next;
      rx_byte    <= byte_next;
      byte_valid <= valid_next;
      frame_err  <= ferr_next;
    end
  end

  // cnt holds the number of cycles until the next sample point; expiry is cnt == 1
  always_comb begin
    rx_next    = rx_state;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    byte_next  = rx_byte;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (!rxd) begin
          rx_next  = RX_START;
          cnt_next = HALF_BIT;
        end
      end
      RX_START: begin
        if (cnt == CW'(1)) begin
          cnt_next = FULL_BIT;
          bit_next = '0;
          rx_next  = rxd ? RX_IDLE : RX_DATA;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == CW'(1)) begin
          byte_next = {rxd, rx_byte[7:1]};
          cnt_next  = FULL_BIT;
          if (bit_idx == 3'd7) rx_next = RX_STOP;
          else                 bit_next = bit_idx + 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == CW'(1)) begin
          valid_next = rxd;
          ferr_next  = ~rxd;
          rx_next    = RX_IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  typedef enum logic [2:0] {P_SYNC, P_COL, P_ROW, P_CODE, P_CLEAR} pkt_state_t;

  pkt_state_t pstate, pnext;
  logic [5:0] col_q, col_next;
  logic [3:0] row_q, row_next;
  logic [9:0] clr_addr, clr_next;
  logic       clear_pending, pend_next;
  logic       we, pkt_err;
  logic [9:0] waddr, code_addr;
  logic [7:0] wdata;

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      pstate        <= P_SYNC;
      col_q         <= '0;
      row_q         <= '0;
      clr_addr      <= '0;
      clear_pending <= 1'b1;
    end else begin
      pstate        <= pnext;
      col_q         <= col_next;
      row_q         <= row_next;
      clr_addr      <= clr_next;
      clear_pending <= pend_next;
    end
  end

  assign code_addr = 10'(row_q) * 10'(COLS) + 10'(col_q);

  // Bytes arriving while P_CLEAR is active fall through untouched and are lost
  always_comb begin
    pnext     = pstate;
    col_next  = col_q;
    row_next  = row_q;
    clr_next  = clr_addr;
    pend_next = clear_pending;
    we        = 1'b0;
    waddr     = code_addr;
    wdata     = rx_byte;
    pkt_done  = 1'b0;
    pkt_err   = 1'b0;
    if (pstate == P_CLEAR) begin
      we    = 1'b1;
      waddr = clr_addr;
      wdata = CLEAR_CODE;
      if (clr_addr == LAST_ADDR) pnext    = P_SYNC;
      else                       clr_next = clr_addr + 1'b1;
    end else if (clear_pending) begin
      pend_next = 1'b0;
      clr_next  = '0;
      pnext     = P_CLEAR;
    end else if (byte_valid) begin
      case (pstate)
        P_SYNC: if (rx_byte == 8'hFF) pnext = P_COL;
        P_COL: begin
          if (rx_byte == 8'hFF) begin
            pnext = P_COL;
          end else if (rx_byte == 8'hFE) begin
            clr_next = '0;
            pnext    = P_CLEAR;
          end else if (rx_byte < COLS_B) begin
            col_next = rx_byte[5:0];
            pnext    = P_ROW;
          end else begin
            pkt_err = 1'b1;
            pnext   = P_SYNC;
          end
        end
        P_ROW: begin
          if (rx_byte == 8'hFF) begin
            pnext = P_COL;
          end else if (rx_byte < ROWS_B) begin
            row_next = rx_byte[3:0];
            pnext    = P_CODE;
          end else begin
            pkt_err = 1'b1;
            pnext   = P_SYNC;
          end
        end
        P_CODE: begin
          we       = 1'b1;
          pkt_done = 1'b1;
          pnext    = P_SYNC;
        end
        default: pnext = P_SYNC;
      endcase
    end
  end

  assign busy = (pstate == P_CLEAR);
  assign err  = frame_err | pkt_err;

  logic [7:0] mem [ROWS*COLS];

  always_ff @(posedge master_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  logic       rd_in_range;
  logic [9:0] raddr;

  assign rd_in_range = (8'(rd_col) < COLS_B) && (8'(rd_row) < ROWS_B);
  assign raddr       = 10'(rd_row) * 10'(COLS) + 10'(rd_col);

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n)         rd_code <= '0;
    else if (rd_in_range) rd_code <= mem[raddr];
    else                  rd_code <= CLEAR_CODE;
  end
endmodule
